jk_cmd_seq: RTL and testbench
=============================

// Module: jk_cmd_seq
// PURPOSE
//  Command sequencer that sits upstream of the jkff stage and produces its j/k drive.
//  Accepts SET/RESET/TOGGLE/HOLD commands over a valid/ready handshake and buffers them in a small FIFO.
//  Plays each command onto j_o/k_o for a programmed number of cycles.
//  Optionally checks the flop's returned q against a shadow model.
// PARAMETERS
//  DEPTH  4  command FIFO entries; power of 2, >=2
//  LEN_W  4  width of per-command cycle count
// PORTS
//  clk          in   1      single clock, all state on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  cmd_valid_i  in   1      command offered
//  cmd_ready_o  out  1      FIFO can accept (= !full)
//  cmd_op_i     in   2      00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//  cmd_len_i    in   LEN_W  drive cycles minus 1 (0 -> 1 cycle)
//  q_i          in   1      q_o returned from the downstream jkff
//  j_o          out  1      registered J drive
//  k_o          out  1      registered K drive
//  busy_o       out  1      FSM in DRIVE
//  done_o       out  1      1-cycle pulse after the last drive cycle of each command
//  err_o        out  1      sticky q mismatch (JK_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - FIFO emptied; FSM=IDLE.
//   - j_o=k_o=0, busy_o=0, done_o=0, err_o=0, rem=0, armed=0.
//   - cmd_ready_o=1 after release.
//  Push: on the edge with cmd_valid_i&cmd_ready_o. No push when full (no write-through).
//  Op encoding -> {j,k}: HOLD 00, RESET 01, SET 10, TOGGLE 11.
//  FSM IDLE:
//   - With FIFO non-empty, pop the head on the next edge.
//   - Load {j_o,k_o} from the op and rem=cmd_len; go to DRIVE.
//  FSM DRIVE:
//   - Each edge with rem>0: rem--.
//   - Edge with rem==0 and FIFO non-empty: pop the next command, no bubble; done_o pulses.
//   - Edge with rem==0 and FIFO empty: j_o=k_o=0, go to IDLE; done_o pulses.
//  Latency:
//   - Command accepted at edge N into an empty FIFO with FSM idle -> popped at edge N+1.
//   - j_o/k_o valid from N+1 for len+1 cycles; the jkff captures first at N+2.
//  Simultaneous push and pop: both take effect; occupancy unchanged.
//   - A push into an empty FIFO is not poppable until the following edge.
//  Pointers are log2(DEPTH)+1 bits; wrap is natural, full = MSBs differ and LSBs equal.
//  Reset mid-command: drive aborts immediately; j_o/k_o=0 asynchronously; queued commands are lost.
// CONFIGURATION
//  JK_CHECK_EN defined:
//   - Shadow exp_q updates each edge as (~exp_q&j_o)|(exp_q&~k_o).
//   - On the first SET/RESET drive edge, exp_q is loaded with the op value and armed=1.
//   - While armed, any cycle with q_i!=exp_q sets err_o; err_o is sticky until reset.
//  JK_CHECK_EN undefined: no shadow logic; err_o tied 0; q_i unused.
// STRUCTURE
//  jk_seq_pkg holds:
//   - typedef enum logic[1:0] jk_op_e {OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE}.
//   - typedef enum state_e {ST_IDLE, ST_DRIVE}.
//   - A function op2jk(jk_op_e) returning the {j,k} pair.
//  Sub-module jk_cmd_fifo (DEPTH, WIDTH=2+LEN_W): push/pop/full/empty, async active-low reset.
// TESTING
//  1. Reset, then SET len=0 at edge N -> j_o=1,k_o=0 during N+1 only; done_o at N+2; q_i=1 afterwards.
//  2. Four back-to-back commands (SET 0, TOGGLE 2, HOLD 1, RESET 0) -> 7 contiguous drive cycles.
//     No idle gaps; done_o pulses 4 times; final q=0.
//  3. Hold valid with the FSM stalled in a long TOGGLE len=15 -> ready drops after DEPTH pushes.
//     No extra entry is written; order is preserved on drain.
//  4. Assert rst_n low mid-TOGGLE with 3 queued -> j_o=k_o=0 immediately; FIFO empty; ready=1 on release.
//  5. JK_CHECK_EN: SET then force q_i=0 for one cycle -> err_o rises next edge and stays 1 until reset.
//  6. JK_CHECK_EN: TOGGLE before any SET/RESET -> err_o stays 0 (unarmed).

Source files
------------

// File: rtl/jk_seq_pkg.sv
// Shared types for the jk_cmd_seq command sequencer: command opcodes, FSM states
// and the opcode to {j,k} mapping.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    function automatic logic [1:0] op2jk(jk_op_e op);
        logic [1:0] jk;
        case (op)
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = 2'b11;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for jk_cmd_seq: extra-MSB pointers, head word shown combinationally,
// push ignored when full and pop ignored when empty.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// Command sequencer driving j/k of a downstream jkff from a queued SET/RESET/TOGGLE/HOLD stream.
// Optional shadow-q checking is built when JK_CHECK_EN is defined; otherwise err_o is tied 0.
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             q_i,
    output logic             j_o,
    output logic             k_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    import jk_seq_pkg::*;

    localparam int WIDTH = 2 + LEN_W;

    state_e           state;
    logic [LEN_W-1:0] rem;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    jk_op_e           head_op;
    logic [LEN_W-1:0] head_len;

    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    assign head_op     = jk_op_e'(head[WIDTH-1:LEN_W]);
    assign head_len    = head[LEN_W-1:0];
    // The last drive cycle pops the next command so back-to-back commands leave no bubble.
    assign pop         = !empty && ((state == ST_IDLE) || (rem == '0));

    jk_cmd_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cmd_op_i, cmd_len_i}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            j_o    <= 1'b0;
            k_o    <= 1'b0;
            rem    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        {j_o, k_o} <= op2jk(head_op);
                        rem        <= head_len;
                        busy_o     <= 1'b1;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (rem != '0) begin
                        rem <= rem - LEN_W'(1);
                    end else begin
                        done_o <= 1'b1;
                        if (!empty) begin
                            {j_o, k_o} <= op2jk(head_op);
                            rem        <= head_len;
                        end else begin
                            {j_o, k_o} <= 2'b00;
                            busy_o     <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef JK_CHECK_EN
    logic exp_q;
    logic armed;
    logic err;

    // With j!=k the JK update equals j, so the first SET/RESET edge also loads the op value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
            armed <= 1'b0;
            err   <= 1'b0;
        end else begin
            exp_q <= (~exp_q & j_o) | (exp_q & ~k_o);
            if (j_o ^ k_o)                armed <= 1'b1;
            if (armed && (q_i != exp_q))  err   <= 1'b1;
        end
    end

    assign err_o = err;
`else
    logic unused_q;
    assign unused_q = q_i;
    assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed scenarios plus random traffic, checked against a timeline
// model computed from command accept times; err_o is modelled when JK_CHECK_EN is defined.
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int TMAX  = 2048;
`ifdef JK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op    = 2'b00;
    logic [LEN_W-1:0] cmd_len   = '0;
    logic             q_ff      = 1'b0;
    logic             q_force   = 1'b0;
    logic             q;
    logic             cmd_ready, j, k, busy, done, err;

    assign q = q_ff ^ q_force;

    jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_len_i  (cmd_len),
        .q_i        (q),
        .j_o        (j),
        .k_o        (k),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Downstream jkff fed by the DUT.
    always @(posedge clk) begin
        case ({j, k})
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    // Timeline model: index = edges since reset release.
    int         t;
    int         n_vec;
    int         n_err;
    logic [1:0] m_jk   [TMAX];
    bit         m_busy [TMAX];
    bit         m_done [TMAX];
    int         a_q[$];
    int         s_q[$];
    int         last_end;
    int         first_arm;
    bit         m_err;
    bit         pend_err;

    function automatic logic [1:0] jk_of(input logic [1:0] op);
        case (op)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int occ(input int tt);
        int n = 0;
        foreach (a_q[i]) if (a_q[i] <= tt) n++;
        foreach (s_q[i]) if (s_q[i] <= tt) n--;
        return n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < TMAX; c++) begin
            m_jk[c]   = 2'b00;
            m_busy[c] = 1'b0;
            m_done[c] = 1'b0;
        end
        a_q.delete();
        s_q.delete();
        last_end  = -10;
        first_arm = -1;
        m_err     = 1'b0;
        t         = 0;
    endtask

    task automatic add_cmd(input int a, input logic [1:0] op, input int len);
        int s;
        int e;
        s = (a + 1 > last_end + 1) ? a + 1 : last_end + 1;
        e = s + len;
        for (int c = s; c <= e; c++) begin
            if (c < TMAX) begin
                m_jk[c]   = jk_of(op);
                m_busy[c] = 1'b1;
            end
        end
        if (e + 1 < TMAX) m_done[e + 1] = 1'b1;
        last_end = e;
        a_q.push_back(a);
        s_q.push_back(s);
        if (first_arm < 0 && (op == 2'b01 || op == 2'b10)) first_arm = s + 1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s t=%0d observed %b expected %b", tag, t, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("j", j, m_jk[t][1]);
        chk("k", k, m_jk[t][0]);
        chk("busy", busy, m_busy[t]);
        chk("done", done, m_done[t]);
        chk("ready", cmd_ready, occ(t) < DEPTH);
        chk("err", err, CHK ? m_err : 1'b0);
    endtask

    // Called at a negedge; presents one cycle of stimulus, then checks after the next edge.
    task automatic cycle(input bit v, input logic [1:0] op, input int len, input bit frc,
                         output bit acc);
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        q_force   = frc;
        acc       = v && (occ(t) < DEPTH);
        if (acc) add_cmd(t + 1, op, len);
        pend_err  = CHK && frc && (first_arm >= 0) && (t >= first_arm);
        @(posedge clk);
        t++;
        @(negedge clk);
        if (pend_err) m_err = 1'b1;
        cmd_valid = 1'b0;
        q_force   = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0, 1'b0, acc);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_j", j, 1'b0);
        chk("rst_async_k", k, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_done", done, 1'b0);
        chk("rst_async_err", err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all();
    endtask

    initial begin
        bit         acc;
        logic [1:0] op_r;
        int         len_r;
        logic [1:0] ops2 [4];
        int         lens2[4];

        n_vec = 0;
        n_err = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single SET, one drive cycle.
        cycle(1'b1, 2'b10, 0, 1'b0, acc);
        idle(4);
        chk("q_after_set", q_ff, 1'b1);

        // Four back-to-back commands.
        ops2[0] = 2'b10; lens2[0] = 0;
        ops2[1] = 2'b11; lens2[1] = 2;
        ops2[2] = 2'b00; lens2[2] = 1;
        ops2[3] = 2'b01; lens2[3] = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, ops2[i], lens2[i], 1'b0, acc);
        idle(10);
        chk("q_after_chain", q_ff, 1'b0);

        // Long TOGGLE stalls the FSM while valid is held until the FIFO fills.
        cycle(1'b1, 2'b11, 15, 1'b0, acc);
        op_r  = 2'($urandom_range(0, 3));
        len_r = $urandom_range(0, 3);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, op_r, len_r, 1'b0, acc);
            if (acc) begin
                op_r  = 2'($urandom_range(0, 3));
                len_r = $urandom_range(0, 3);
            end
        end
        idle(70);

        // Reset in the middle of a TOGGLE with three commands queued.
        cycle(1'b1, 2'b11, 7, 1'b0, acc);
        cycle(1'b1, 2'b10, 3, 1'b0, acc);
        cycle(1'b1, 2'b00, 2, 1'b0, acc);
        cycle(1'b1, 2'b01, 1, 1'b0, acc);
        idle(1);
        do_reset();
        idle(6);

        // Unarmed mismatch is ignored; armed mismatch is sticky.
        cycle(1'b1, 2'b11, 2, 1'b0, acc);
        cycle(1'b0, 2'b00, 0, 1'b1, acc);
        cycle(1'b0, 2'b00, 0, 1'b1, acc);
        idle(3);
        cycle(1'b1, 2'b10, 1, 1'b0, acc);
        idle(4);
        cycle(1'b0, 2'b00, 0, 1'b1, acc);
        idle(5);
        do_reset();

        // Random traffic with occasional q faults and resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
                      ($urandom_range(0, 29) == 0), acc);
            end
        end
        idle(90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
